// File: rtl/display_scanout.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// display_scanout
//
// Raster timing generator and pixel pipeline for a line- and column-doubled
// framebuffer. The framebuffer stores one RGB332 byte per 2x2 block of screen
// pixels. This block walks the raster, presents a byte address to the
// graphics memory, and turns the byte that comes back one clock later into
// colour, sync and blanking outputs.
//
// Pipeline
//   S0 : raster counters (hcount, vcount) and the combinational memory
//        address for that position.
//   S1 : timing flags for the S0 position, delayed one clock so they line
//        up with the byte that graphics memory returns.
//   S2 : registered outputs. They show S0 position (h, v) exactly two clocks
//        after the counters held (h, v).
//
// Ports
//   clk          in   pixel clock, also clocks the graphics-memory read port
//   rst          in   asynchronous reset, active high
//   gpu_address  out  byte address into graphics memory (combinational, S0)
//   gpu_data     in   byte for the address presented one clock earlier
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   data_enable  out  high while red/green/blue carry a visible pixel
//   red          out  gpu_data[7:5] when visible, else 0
//   green        out  gpu_data[4:2] when visible, else 0
//   blue         out  gpu_data[1:0] when visible, else 0
//   vblank       out  high while the output-stage line is outside the
//                     visible area
//   frame_start  out  one-clock pulse while the output stage shows (0,0)
// ---------------------------------------------------------------------------
module display_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FRONT  = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BACK   = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FRONT  = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BACK   = 33,
    parameter int          FB_WIDTH = 320,
    parameter logic [31:0] FB_BASE  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] gpu_address,
    input  logic [7:0]  gpu_data,
    output logic        hsync,
    output logic        vsync,
    output logic        data_enable,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        vblank,
    output logic        frame_start
);

    localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST    = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST    = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // S0 raster position and framebuffer row base
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [31:0]   row_base;

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic active_s0;
    logic hsync_s0;
    logic vsync_s0;
    logic vblank_s0;
    logic frame_start_s0;

    // S1 flags, aligned with gpu_data
    logic active_s1;
    logic hsync_s1;
    logic vsync_s1;
    logic vblank_s1;
    logic frame_start_s1;

    // ------------------------------------------------------------------
    // S0: raster counters
    // ------------------------------------------------------------------
    assign h_wrap = (hcount == H_LAST);
    assign v_wrap = (vcount == V_LAST);

    // row_base tracks FB_BASE + (vcount >> 1) * FB_WIDTH incrementally:
    // it steps by one framebuffer row after each odd visible line, so
    // every framebuffer row is scanned on two consecutive lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount   <= '0;
            vcount   <= '0;
            row_base <= FB_BASE;
        end else if (h_wrap) begin
            hcount <= '0;
            if (v_wrap) begin
                vcount   <= '0;
                row_base <= FB_BASE;
            end else begin
                vcount <= vcount + 1'b1;
                if (v_active && vcount[0]) begin
                    row_base <= row_base + 32'(FB_WIDTH);
                end
            end
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // S0: address and timing flags for the current position
    // ------------------------------------------------------------------
    assign h_active  = (hcount < H_ACT_END);
    assign v_active  = (vcount < V_ACT_END);
    assign active_s0 = h_active && v_active;

    // Column doubling comes from dropping hcount[0]; in blanking the
    // address parks on FB_BASE so the memory port sees a stable value.
    assign gpu_address = active_s0 ? (row_base + 32'(hcount >> 1)) : FB_BASE;

    assign hsync_s0       = !((hcount >= HS_BEG) && (hcount < HS_END));
    assign vsync_s0       = !((vcount >= VS_BEG) && (vcount < VS_END));
    assign vblank_s0      = !v_active;
    assign frame_start_s0 = (hcount == '0) && (vcount == '0);

    // ------------------------------------------------------------------
    // S1: delay flags one clock to meet the memory read latency
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_s1      <= 1'b0;
            hsync_s1       <= 1'b1;
            vsync_s1       <= 1'b1;
            vblank_s1      <= 1'b0;
            frame_start_s1 <= 1'b0;
        end else begin
            active_s1      <= active_s0;
            hsync_s1       <= hsync_s0;
            vsync_s1       <= vsync_s0;
            vblank_s1      <= vblank_s0;
            frame_start_s1 <= frame_start_s0;
        end
    end

    // ------------------------------------------------------------------
    // S2: registered outputs; gpu_data is discarded outside the visible
    // area so whatever the memory returns in blanking never reaches the
    // colour pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_enable <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            data_enable <= active_s1;
            red         <= active_s1 ? gpu_data[7:5] : 3'd0;
            green       <= active_s1 ? gpu_data[4:2] : 3'd0;
            blue        <= active_s1 ? gpu_data[1:0] : 2'd0;
            hsync       <= hsync_s1;
            vsync       <= vsync_s1;
            vblank      <= vblank_s1;
            frame_start <= frame_start_s1;
        end
    end

endmodule
